label_allocator: RTL

Sequential allocator directly upstream of the label table. It accepts label declarations (label id, type, element count), bump-allocates a contiguous region of word-addressed data memory, and can zero-fill that region. It then commits the entry through the label table's write port (`we`, `lbidw`, `typw`, `basew`, `countw`). The free pointer only grows until an explicit clear; there is no per-label reclaim.

---
 rtl/label_allocator_pkg.sv | 23 ++
 rtl/label_allocator_if.sv | 43 ++++
 rtl/label_zero_fill.sv | 56 +++++
 rtl/label_allocator.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/label_allocator_pkg.sv
// Shared types and widths for the label allocator and its zero-fill helper.
package label_allocator_pkg;

  localparam int unsigned TypWidth   = 6;
  localparam int unsigned BaseWidth  = 16;
  localparam int unsigned CountWidth = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ZERO,
    ST_WRITE,
    ST_ERR
  } state_e;

  // Declaration fields latched on acceptance (lbid width is a module parameter).
  typedef struct packed {
    logic [TypWidth-1:0]   typ;
    logic [CountWidth-1:0] count;
    logic                  zero;
  } req_s;

endpackage

// File: rtl/label_allocator_if.sv
// Request, label-table write and data-memory write signals of the allocator.
interface label_allocator_if #(
  parameter int unsigned LBIDWidth    = 8,
  parameter int unsigned MemAddrWidth = 16,
  parameter int unsigned DataWidth    = 32
);
  import label_allocator_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [LBIDWidth-1:0]    req_lbid;
  logic [TypWidth-1:0]     req_typ;
  logic [CountWidth-1:0]   req_count;
  logic                    req_zero;
  logic                    clr;

  logic                    lt_we;
  logic [LBIDWidth-1:0]    lt_lbidw;
  logic [TypWidth-1:0]     lt_typw;
  logic [BaseWidth-1:0]    lt_basew;
  logic [CountWidth-1:0]   lt_countw;

  logic                    mem_we;
  logic [MemAddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0]    mem_wdata;

  logic                    done;
  logic                    err;
  logic [MemAddrWidth:0]   free_ptr;

  modport master (
    output req_valid, req_lbid, req_typ, req_count, req_zero, clr,
    input  req_ready, lt_we, lt_lbidw, lt_typw, lt_basew, lt_countw,
    input  mem_we, mem_addr, mem_wdata, done, err, free_ptr
  );

  modport slave (
    input  req_valid, req_lbid, req_typ, req_count, req_zero, clr,
    output req_ready, lt_we, lt_lbidw, lt_typw, lt_basew, lt_countw,
    output mem_we, mem_addr, mem_wdata, done, err, free_ptr
  );

endinterface

// File: rtl/label_zero_fill.sv
// Address generator for zero-fill: one registered write strobe per word, base..base+count-1.
module label_zero_fill
  import label_allocator_pkg::*;
#(
  parameter int unsigned AddrWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AddrWidth-1:0]  base,
  input  logic [CountWidth-1:0] count,
  output logic                  busy,
  output logic                  last_c,
  output logic [AddrWidth-1:0]  addr
);

  logic                  busy_q, busy_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [CountWidth-1:0] rem_q, rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  // rem counts words still to write after the current one.
  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    rem_d  = rem_q;
    if (start && (count != '0)) begin
      busy_d = 1'b1;
      addr_d = base;
      rem_d  = count - CountWidth'(1);
    end else if (busy_q) begin
      if (rem_q == '0) begin
        busy_d = 1'b0;
      end else begin
        addr_d = addr_q + AddrWidth'(1);
        rem_d  = rem_q - CountWidth'(1);
      end
    end
  end

  assign busy   = busy_q;
  assign addr   = addr_q;
  assign last_c = busy_q && (rem_q == '0);

endmodule

// File: rtl/label_allocator.sv
// Bump allocator for label regions: range check, optional zero-fill, then one label-table write.
module label_allocator
  import label_allocator_pkg::*;
#(
  parameter int unsigned LBIDWidth    = 8,
  parameter int unsigned MemAddrWidth = 16,
  parameter int unsigned DataWidth    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  label_allocator_if.slave bus
);

  localparam int unsigned PtrWidth = MemAddrWidth + 1;
  localparam int unsigned EndWidth =
    (MemAddrWidth + 2 > CountWidth + 1) ? MemAddrWidth + 2 : CountWidth + 1;
  localparam logic [EndWidth-1:0] Capacity = EndWidth'(1) << MemAddrWidth;

  state_e                state_q, state_d;
  logic [PtrWidth-1:0]   free_ptr_q, free_ptr_d;
  logic [LBIDWidth-1:0]  lbid_q, lbid_d;
  req_s                  req_q, req_d;

  logic                  ready_q, ready_d;
  logic                  lt_we_q, lt_we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [LBIDWidth-1:0]  lt_lbid_q, lt_lbid_d;
  logic [TypWidth-1:0]   lt_typ_q, lt_typ_d;
  logic [BaseWidth-1:0]  lt_base_q, lt_base_d;
  logic [CountWidth-1:0] lt_count_q, lt_count_d;

  logic [EndWidth-1:0]     end_c;
  logic                    fill_start_c;
  logic                    fill_busy;
  logic                    fill_last_c;
  logic [MemAddrWidth-1:0] fill_addr;

  // Wide enough that the sum never wraps.
  assign end_c = EndWidth'(free_ptr_q) + EndWidth'(req_q.count);

  label_zero_fill #(
    .AddrWidth (MemAddrWidth)
  ) u_fill (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (fill_start_c),
    .base   (free_ptr_q[MemAddrWidth-1:0]),
    .count  (req_q.count),
    .busy   (fill_busy),
    .last_c (fill_last_c),
    .addr   (fill_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      free_ptr_q <= '0;
      lbid_q     <= '0;
      req_q      <= '0;
      ready_q    <= 1'b1;
      lt_we_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      lt_lbid_q  <= '0;
      lt_typ_q   <= '0;
      lt_base_q  <= '0;
      lt_count_q <= '0;
    end else begin
      state_q    <= state_d;
      free_ptr_q <= free_ptr_d;
      lbid_q     <= lbid_d;
      req_q      <= req_d;
      ready_q    <= ready_d;
      lt_we_q    <= lt_we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      lt_lbid_q  <= lt_lbid_d;
      lt_typ_q   <= lt_typ_d;
      lt_base_q  <= lt_base_d;
      lt_count_q <= lt_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    free_ptr_d   = free_ptr_q;
    lbid_d       = lbid_q;
    req_d        = req_q;
    fill_start_c = 1'b0;
    lt_lbid_d    = lt_lbid_q;
    lt_typ_d     = lt_typ_q;
    lt_base_d    = lt_base_q;
    lt_count_d   = lt_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.clr) begin
          free_ptr_d = '0;
        end else if (bus.req_valid) begin
          lbid_d      = bus.req_lbid;
          req_d.typ   = bus.req_typ;
          req_d.count = bus.req_count;
          req_d.zero  = bus.req_zero;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (end_c > Capacity) begin
          state_d = ST_ERR;
        end else if (req_q.zero && (req_q.count != '0)) begin
          state_d      = ST_ZERO;
          fill_start_c = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_ZERO: begin
        if (fill_last_c) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        free_ptr_d = end_c[PtrWidth-1:0];
        state_d    = ST_IDLE;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes registered from the next state so each lines up with its state cycle.
    ready_d = (state_d == ST_IDLE);
    lt_we_d = (state_d == ST_WRITE);
    done_d  = (state_d == ST_WRITE);
    err_d   = (state_d == ST_ERR);
    if (state_d == ST_WRITE) begin
      lt_lbid_d  = lbid_q;
      lt_typ_d   = req_q.typ;
      lt_base_d  = BaseWidth'(free_ptr_q[MemAddrWidth-1:0]);
      lt_count_d = req_q.count;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.lt_we     = lt_we_q;
  assign bus.lt_lbidw  = lt_lbid_q;
  assign bus.lt_typw   = lt_typ_q;
  assign bus.lt_basew  = lt_base_q;
  assign bus.lt_countw = lt_count_q;
  assign bus.mem_we    = fill_busy;
  assign bus.mem_addr  = fill_addr;
  assign bus.mem_wdata = '0;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.free_ptr  = free_ptr_q;

endmodule
